// File: rtl/game_ctrl_if.sv
// Frame/flap/collide inputs and bird/scroll/score outputs of the gameplay engine.
// Inputs are single-cycle pulses; outputs are registered and change only after
// a new_frame edge, so a consumer samples them any time between frame pulses.
interface game_ctrl_if;
    logic        new_frame;
    logic        flap;
    logic        collide;
    logic [15:0] bird_y;
    logic [7:0]  stage_shift;
    logic [1:0]  game_state;
    logic [15:0] score;

    modport master (
        output new_frame, flap, collide,
        input  bird_y, stage_shift, game_state, score
    );

    modport slave (
        input  new_frame, flap, collide,
        output bird_y, stage_shift, game_state, score
    );
endinterface

// File: rtl/game_ctrl.sv
// Per-frame gameplay engine: flap pulses become bird motion under gravity,
// the pipe scroll offset advances each PLAY frame, and the score counts
// scroll wraps. game_state doubles as the visible FSM state.
module game_ctrl #(
    parameter int START_Y     = 200,
    parameter int GROUND_Y    = 400,
    parameter int FLAP_V      = 8,
    parameter int GRAVITY     = 1,
    parameter int VMAX        = 10,
    parameter int SCROLL_STEP = 2,
    parameter int DEAD_HOLD   = 30
) (
    input  logic        clk,
    input  logic        rstn,
    game_ctrl_if.slave  gif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [15:0] START16  = START_Y[15:0];
    localparam logic [15:0] GROUND16 = GROUND_Y[15:0];
    localparam logic [7:0]  FLAP8    = FLAP_V[7:0];
    localparam logic [7:0]  NEG_FLAP = ~FLAP8 + 8'd1;
    localparam logic [8:0]  GRAV9    = GRAVITY[8:0];
    localparam logic [8:0]  VMAX9    = VMAX[8:0];
    localparam logic [7:0]  STEP8    = SCROLL_STEP[7:0];
    localparam logic [7:0]  HOLD8    = DEAD_HOLD[7:0];

    state_t             state, state_n;
    logic [15:0]        bird_y_q, bird_y_n;
    logic signed [7:0]  vel_q, vel_n;
    logic [7:0]         shift_q, shift_n;
    logic [15:0]        score_q, score_n;
    logic [7:0]         hold_q, hold_n;
    logic               flap_pending;

    // A flap in the same cycle as new_frame still belongs to that frame.
    logic               flap_eff;
    logic [8:0]         vel_inc;
    logic [7:0]         vel_cand;
    logic [16:0]        y_sum;
    logic [8:0]         shift_sum;
    logic               hit_ground;

    assign flap_eff = flap_pending | gif.flap;

    // Candidate motion for a PLAY frame: flap resets speed, else gravity clamped at VMAX.
    always_comb begin
        vel_inc = {vel_q[7], vel_q} + GRAV9;
        if (flap_eff) begin
            vel_cand = NEG_FLAP;
        end else if ($signed(vel_inc) > $signed(VMAX9)) begin
            vel_cand = VMAX9[7:0];
        end else begin
            vel_cand = vel_inc[7:0];
        end
        y_sum      = {1'b0, bird_y_q} + {{9{vel_cand[7]}}, vel_cand};
        hit_ground = !y_sum[16] && (y_sum[15:0] >= GROUND16);
        shift_sum  = {1'b0, shift_q} + {1'b0, STEP8};
    end

    // Next-state and next-value logic, applied only on new_frame edges.
    always_comb begin
        state_n  = state;
        bird_y_n = bird_y_q;
        vel_n    = vel_q;
        shift_n  = shift_q;
        score_n  = score_q;
        hold_n   = hold_q;
        case (state)
            IDLE: begin
                bird_y_n = START16;
                vel_n    = '0;
                shift_n  = '0;
                hold_n   = '0;
                if (flap_eff) begin
                    state_n  = PLAY;
                    vel_n    = NEG_FLAP;
                    bird_y_n = START16 - {8'd0, FLAP8};
                    shift_n  = STEP8;
                end
            end
            PLAY: begin
                if (gif.collide) begin
                    state_n = DEAD;
                    hold_n  = '0;
                end else if (hit_ground) begin
                    state_n  = DEAD;
                    bird_y_n = GROUND16;
                    hold_n   = '0;
                end else begin
                    if (y_sum[16]) begin
                        bird_y_n = '0;
                        vel_n    = '0;
                    end else begin
                        bird_y_n = y_sum[15:0];
                        vel_n    = vel_cand;
                    end
                    shift_n = shift_sum[7:0];
                    if (shift_sum[8] && (score_q != 16'hFFFF)) begin
                        score_n = score_q + 16'd1;
                    end
                end
            end
            DEAD: begin
                if ((hold_q >= HOLD8) && flap_eff) begin
                    state_n  = IDLE;
                    bird_y_n = START16;
                    vel_n    = '0;
                    shift_n  = '0;
                    score_n  = '0;
                    hold_n   = '0;
                end else if (hold_q < HOLD8) begin
                    hold_n = hold_q + 8'd1;
                end
            end
            default: begin
                state_n  = IDLE;
                bird_y_n = START16;
                vel_n    = '0;
                shift_n  = '0;
                score_n  = '0;
                hold_n   = '0;
            end
        endcase
    end

    // Frame-rate state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bird_y_q <= START16;
            vel_q    <= '0;
            shift_q  <= '0;
            score_q  <= '0;
            hold_q   <= '0;
        end else if (gif.new_frame) begin
            state    <= state_n;
            bird_y_q <= bird_y_n;
            vel_q    <= vel_n;
            shift_q  <= shift_n;
            score_q  <= score_n;
            hold_q   <= hold_n;
        end
    end

    // Remember any flap since the last frame; every frame consumes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flap_pending <= 1'b0;
        end else if (gif.new_frame) begin
            flap_pending <= 1'b0;
        end else if (gif.flap) begin
            flap_pending <= 1'b1;
        end
    end

    assign gif.bird_y      = bird_y_q;
    assign gif.stage_shift = shift_q;
    assign gif.game_state  = state;
    assign gif.score       = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl. Each driven frame pushes its expected outputs
// {check, state, bird_y, shift, score}; a monitor pops one entry per frame
// pulse and compares on the following falling edge.
module tb_game_ctrl;
    localparam int W = 43;

    logic clk;
    logic rstn;
    game_ctrl_if gif ();

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .gif  (gif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [1:0] st, input logic [15:0] y,
                       input logic [7:0] sh, input logic [15:0] sc);
        n_tests++;
        if (gif.game_state !== st || gif.bird_y !== y || gif.stage_shift !== sh || gif.score !== sc) begin
            n_fail++;
            $display("FAIL %s: got state=%0d y=%0d shift=%0d score=%0d, want state=%0d y=%0d shift=%0d score=%0d",
                     name, gif.game_state, gif.bird_y, gif.stage_shift, gif.score, st, y, sh, sc);
        end
    endtask

    // driver: one frame with optional flap (1=early pulse, 2=with new_frame, 3=two pulses)
    task automatic frame(input int mode, input bit col, input bit chk, input logic [1:0] st,
                         input logic [15:0] y, input logic [7:0] sh, input logic [15:0] sc);
        exp_q.push_back({chk, st, y, sh, sc});
        if (mode == 1 || mode == 3) begin
            @(posedge clk); #1 gif.flap = 1'b1;
            @(posedge clk); #1 gif.flap = 1'b0;
        end
        if (mode == 3) begin
            @(posedge clk); #1 gif.flap = 1'b1;
            @(posedge clk); #1 gif.flap = 1'b0;
        end
        @(posedge clk); #1;
        gif.new_frame = 1'b1;
        gif.collide   = col;
        gif.flap      = (mode == 2);
        @(posedge clk); #1;
        gif.new_frame = 1'b0;
        gif.collide   = 1'b0;
        gif.flap      = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // asynchronous reset between clock edges, checked before any edge arrives
    task automatic async_reset(input string name);
        @(posedge clk); #3 rstn = 1'b0;
        #1 cmp(name, 2'd0, 16'd200, 8'd0, 16'd0);
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            if (rstn && gif.new_frame) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_queue: got an output frame, want a queued expectation");
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (gif.bird_y > 16'd400) begin
                        n_fail++;
                        $display("FAIL ground_limit: got y=%0d, want y<=400", gif.bird_y);
                    end
                    if (e[42]) cmp("frame", e[41:40], e[39:24], e[23:16], e[15:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [15:0] ey;
        logic [7:0]  es;
        logic [15:0] ec;
        bit          chk;
        rstn          = 1'b0;
        gif.new_frame = 1'b0;
        gif.flap      = 1'b0;
        gif.collide   = 1'b0;
        repeat (3) @(posedge clk);
        #1 cmp("reset", 2'd0, 16'd200, 8'd0, 16'd0);
        rstn = 1'b1;

        // idle frames without flaps
        for (int i = 0; i < 5; i++) frame(0, 0, 1, 2'd0, 16'd200, 8'd0, 16'd0);

        // start with a flap, then free fall to the ground
        frame(1, 0, 1, 2'd1, 16'd192, 8'd2, 16'd0);
        for (int j = 1; j <= 37; j++) begin
            chk = 1'b1;
            ey  = 16'd0;
            case (j)
                1:  ey = 16'd185;
                2:  ey = 16'd179;
                3:  ey = 16'd174;
                18: ey = 16'd219;
                36: ey = 16'd399;
                37: ey = 16'd400;
                default: chk = 1'b0;
            endcase
            es = (j == 37) ? 8'd74 : 8'(2 + 2 * j);
            frame(0, 0, chk, (j == 37) ? 2'd2 : 2'd1, ey, es, 16'd0);
        end
        frame(0, 0, 1, 2'd2, 16'd400, 8'd74, 16'd0);
        frame(1, 0, 1, 2'd2, 16'd400, 8'd74, 16'd0);
        async_reset("reset_in_dead");

        // flap every frame up to the ceiling, mixing flap timings
        for (int k = 1; k <= 26; k++) begin
            ey = (k <= 25) ? 16'(200 - 8 * k) : 16'd0;
            frame(1 + (k % 3), 0, 1, 2'd1, ey, 8'(2 * k), 16'd0);
        end
        frame(0, 0, 1, 2'd1, 16'd1, 8'd54, 16'd0);
        // collide wins over a simultaneous flap
        frame(1, 1, 1, 2'd2, 16'd1, 8'd54, 16'd0);
        // dead hold: flaps ignored until 30 frames have passed
        for (int d = 1; d <= 31; d++) begin
            if (d < 31) frame((d == 10 || d == 30) ? 1 : 0, 0, 1, 2'd2, 16'd1, 8'd54, 16'd0);
            else        frame(1, 0, 1, 2'd0, 16'd200, 8'd0, 16'd0);
        end
        frame(0, 0, 1, 2'd0, 16'd200, 8'd0, 16'd0);
        async_reset("reset_in_idle");

        // 128 PLAY frames kept alive by a flap every 16 frames: shift wraps, score increments
        for (int f = 1; f <= 128; f++) begin
            chk = 1'b1;
            ey  = 16'd0;
            es  = 8'd0;
            ec  = 16'd0;
            case (f)
                16:  begin ey = 16'd192; es = 8'd32;  end
                64:  begin ey = 16'd168; es = 8'd128; end
                127: begin ey = 16'd129; es = 8'd254; end
                128: begin ey = 16'd136; es = 8'd0; ec = 16'd1; end
                default: chk = 1'b0;
            endcase
            frame(((f - 1) % 16 == 0) ? 1 : 0, 0, chk, 2'd1, ey, es, ec);
        end
        async_reset("reset_in_play");
        frame(0, 0, 1, 2'd0, 16'd200, 8'd0, 16'd0);

        repeat (4) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
